// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt request encoder.
package irq_pkg;

  localparam int IRQ_N = 4;
  localparam int IRQ_W = 2;

  // Ceiling log2; used at elaboration to confirm that W matches N.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  typedef enum logic {
    IRQ_IDLE    = 1'b0,
    IRQ_PRESENT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/prio_encoder.sv
// Combinational priority encoder, N -> W, highest set index wins.
// Inverse of the 2-to-4 decoder; `none` flags an all-zero input.
module prio_encoder
  import irq_pkg::*;
#(
  parameter int N = IRQ_N,
  parameter int W = IRQ_W
) (
  input  logic [N-1:0] in,
  output logic [W-1:0] code,
  output logic         none
);

  // Ascending scan, so the last (highest) set bit overrides lower ones.
  always_comb begin
    code = '0;
    none = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (in[i]) begin
        code = W'(i);
        none = 1'b0;
      end
    end
  end

endmodule

// File: rtl/irq_encoder.sv
// Interrupt request encoder: edge capture into pending, masked priority
// selection, and a two-state irq/ack presentation FSM with a frozen code.
module irq_encoder
  import irq_pkg::*;
#(
  parameter int N = IRQ_N,
  parameter int W = IRQ_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         mask_we,
  input  logic [N-1:0] mask_in,
  input  logic         ack,
  output logic         irq,
  output logic [W-1:0] code,
  output logic [N-1:0] pending,
  output logic [N-1:0] mask
);

  // State | meaning
  // IRQ_IDLE    | irq low, waiting for an enabled pending candidate
  // IRQ_PRESENT | irq high, code frozen until ack or en drops

  if (W != clog2(N)) begin : g_bad_width
    $error("irq_encoder: W must equal log2(N)");
  end

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  irq_state_e   state;
  logic [N-1:0] req_q;
  logic [N-1:0] rise;
  logic [N-1:0] cand;
  logic [N-1:0] clr;
  logic [W-1:0] win;
  logic         none;

  assign rise = req & ~req_q;
  // Uses the mask register as it stands, so a same-cycle mask write only
  // takes effect from the next selection.
  assign cand = pending & mask;
  assign clr  = (state == IRQ_PRESENT && ack) ? (ONE << code) : '0;

  prio_encoder #(.N(N), .W(W)) u_prio (
    .in   (cand),
    .code (win),
    .none (none)
  );

  // Request edge capture and mask register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
      mask  <= '1;
    end else begin
      req_q <= req;
      if (mask_we) mask <= mask_in;
    end
  end

  // Pending bits: a new rising edge wins over a same-cycle ack clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr) | rise;
  end

  // Presentation FSM with registered irq/code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IRQ_IDLE;
      irq   <= 1'b0;
      code  <= '0;
    end else begin
      case (state)
        IRQ_IDLE: begin
          if (en && !none) begin
            code  <= win;
            irq   <= 1'b1;
            state <= IRQ_PRESENT;
          end
        end
        IRQ_PRESENT: begin
          // ack takes precedence; dropping en alone withdraws without clearing.
          if (ack || !en) begin
            irq   <= 1'b0;
            state <= IRQ_IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          state <= IRQ_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_encoder.sv
// Scoreboard bench for irq_encoder: stimulus pushes expected codes,
// a monitor pops and compares on each rising irq.
module tb_irq_encoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b1;
  logic [N-1:0] req = '0;
  logic         mask_we = 1'b0;
  logic [N-1:0] mask_in = '0;
  logic         ack = 1'b0;
  logic         irq;
  logic [W-1:0] code;
  logic [N-1:0] pending;
  logic [N-1:0] mask;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  irq_encoder #(.N(N), .W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .req     (req),
    .mask_we (mask_we),
    .mask_in (mask_in),
    .ack     (ack),
    .irq     (irq),
    .code    (code),
    .pending (pending),
    .mask    (mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every rising irq must match the next queued code.
  initial begin
    logic irq_prev;
    irq_prev = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (irq && !irq_prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_irq: got code %0d expected no interrupt at %0t", code, $time);
        end else begin
          chk("sb_code", 32'(code), 32'(exp_q.pop_front()));
        end
      end
      irq_prev = irq;
    end
  end

  initial begin
    #20;
    chk("rst_irq", 32'(irq), 0);
    chk("rst_code", 32'(code), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_mask", 32'(mask), 32'hF);
    rst_n = 1'b1;
    step();

    // 1: single request, 2-cycle latency, ack clears.
    exp_q.push_back(2'd2);
    req = 4'b0100; step();
    chk("t1_pend", 32'(pending), 32'b0100);
    chk("t1_irq_early", 32'(irq), 0);
    req = 4'b0000; step();
    chk("t1_irq", 32'(irq), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t1_ack_irq", 32'(irq), 0);
    chk("t1_ack_pend", 32'(pending), 0);

    // 2: two simultaneous sources, highest first, one idle cycle between.
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    req = 4'b1001; step();
    req = 4'b0000; step();
    chk("t2_irq3", 32'(irq), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t2_idle_gap", 32'(irq), 0);
    step();
    chk("t2_irq0", 32'(irq), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t2_pend", 32'(pending), 0);

    // 3: no preemption by a higher-priority arrival.
    exp_q.push_back(2'd0);
    req = 4'b0001; step();
    req = 4'b0000; step();
    req = 4'b1000; step();
    req = 4'b0000; step();
    chk("t3_frozen_code", 32'(code), 0);
    chk("t3_frozen_irq", 32'(irq), 1);
    chk("t3_pend", 32'(pending), 32'b1001);
    exp_q.push_back(2'd3);
    ack = 1'b1; step(); ack = 1'b0;
    step();
    chk("t3_irq3", 32'(irq), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t3_pend_clr", 32'(pending), 0);

    // 4: masked source latches but is not presented until unmasked.
    mask_in = 4'b1110; mask_we = 1'b1; step(); mask_we = 1'b0;
    chk("t4_mask", 32'(mask), 32'b1110);
    req = 4'b0001; step();
    req = 4'b0000; step();
    step();
    chk("t4_pend", 32'(pending), 32'b0001);
    chk("t4_irq_masked", 32'(irq), 0);
    exp_q.push_back(2'd0);
    mask_in = 4'b1111; mask_we = 1'b1; step(); mask_we = 1'b0;
    chk("t4_old_mask_used", 32'(irq), 0);
    chk("t4_mask_new", 32'(mask), 32'hF);
    step();
    chk("t4_irq", 32'(irq), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t4_pend_clr", 32'(pending), 0);

    // 5a: en drop withdraws without clearing; re-presented on en return.
    exp_q.push_back(2'd1);
    req = 4'b0010; step();
    req = 4'b0000; step();
    chk("t5_irq", 32'(irq), 1);
    en = 1'b0; step();
    chk("t5_en_drop_irq", 32'(irq), 0);
    chk("t5_en_drop_pend", 32'(pending), 32'b0010);
    step();
    chk("t5_en_off_idle", 32'(irq), 0);
    exp_q.push_back(2'd1);
    en = 1'b1; step();
    chk("t5_repres", 32'(irq), 1);

    // 5b: rising edge coincident with ack of the same source: set wins.
    req = 4'b0010; ack = 1'b1; step();
    req = 4'b0000; ack = 1'b0;
    chk("t5_set_wins_pend", 32'(pending), 32'b0010);
    chk("t5_set_wins_irq", 32'(irq), 0);
    exp_q.push_back(2'd1);
    step();
    chk("t5_repres2", 32'(irq), 1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("t5_pend_clr", 32'(pending), 0);

    // 6: asynchronous reset mid-PRESENT.
    mask_in = 4'b0111; mask_we = 1'b1; step(); mask_we = 1'b0;
    exp_q.push_back(2'd1);
    req = 4'b1010; step();
    req = 4'b0000; step();
    chk("t6_irq", 32'(irq), 1);
    chk("t6_pend", 32'(pending), 32'b1010);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_irq", 32'(irq), 0);
    chk("t6_rst_code", 32'(code), 0);
    chk("t6_rst_pend", 32'(pending), 0);
    chk("t6_rst_mask", 32'(mask), 32'hF);
    step();
    rst_n = 1'b1;
    step(); step();
    chk("t6_after_irq", 32'(irq), 0);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
